// File: rtl/gen_step_scheduler_pkg.sv
// Shared definitions for the generation step scheduler: FSM encodings and default divider width.
package gen_step_scheduler_pkg;
  localparam int N_DEFAULT = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    REQ   = 2'd2
  } sched_state_t;
endpackage

// File: rtl/gen_step_scheduler_rate_divider.sv
// Free-running N-bit rate divider; tick when the low rate bits of the count are all ones.
// The count restarts from zero in the cycle run rises, so the first tick always lands 2^rate-1 later.
module rate_divider
  import gen_step_scheduler_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rstn,
  input  logic       run,
  input  logic [4:0] rate,
  output logic       tick
);
  localparam logic [N-1:0] ONE = 1;

  logic [N-1:0] count;
  logic [N-1:0] cnt_eff;
  logic [N-1:0] mask;
  logic         run_q;
  logic         run_rise;

  assign run_rise = run & ~run_q;
  assign cnt_eff  = run_rise ? '0 : count;

  // Bits at or above N are never set, so rate values beyond N clamp naturally.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i < int'(rate));
    end
  end

  assign tick = &(cnt_eff | ~mask);

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      run_q <= 1'b0;
    end else begin
      count <= cnt_eff + ONE;
      run_q <= run;
    end
  end
endmodule

// File: rtl/gen_step_scheduler.sv
// Generation step scheduler: turns divider ticks / single steps into vblank-gated req/ack handshakes.
// Optional SCHED_PENDING_EN keeps one pending tick/step that arrived while busy.
module gen_step_scheduler
  import gen_step_scheduler_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rstn,
  input  logic        run,
  input  logic        step,
  input  logic [4:0]  rate,
  input  logic        vblank,
  input  logic        ack,
  output logic        req,
  output logic        busy,
  output logic [15:0] gen_count
);
  sched_state_t state, state_nxt;
  logic step_q;
  logic step_rise;
  logic tick;
  logic evt;
  logic arm_pend;

  rate_divider #(.N(N)) u_rate_divider (
    .clk_in (clk_in),
    .rstn   (rstn),
    .run    (run),
    .rate   (rate),
    .tick   (tick)
  );

  assign step_rise = step & ~step_q;
  assign evt       = (run & tick) | (~run & step_rise);

`ifdef SCHED_PENDING_EN
  logic pend;
  logic run_q;
  logic run_fall;

  assign run_fall = run_q & ~run;
  assign arm_pend = pend & ~run_fall;

  // Pending flag is consumed on any IDLE cycle, since IDLE with the flag set arms immediately.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      pend  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      run_q <= run;
      if (run_fall || state == IDLE) begin
        pend <= 1'b0;
      end else if (evt) begin
        pend <= 1'b1;
      end
    end
  end
`else
  assign arm_pend = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (evt || arm_pend) state_nxt = ARMED;
      ARMED:   if (vblank) state_nxt = REQ;
      REQ:     if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      step_q    <= 1'b0;
      req       <= 1'b0;
      gen_count <= '0;
    end else begin
      state  <= state_nxt;
      step_q <= step;
      req    <= (state_nxt == REQ);
      if (state == REQ && ack) begin
        gen_count <= gen_count + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);
endmodule
